// File: rtl/hpi_ctrl_pkg.sv
// HPI access controller shared types.
// State encoding and HPI register selects.
package hpi_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_DONE,
    ST_RECOVER
  } hpi_state_e;

  localparam logic [1:0] HPI_DATA    = 2'd0;
  localparam logic [1:0] HPI_MAILBOX = 2'd1;
  localparam logic [1:0] HPI_ADDRESS = 2'd2;
  localparam logic [1:0] HPI_STATUS  = 2'd3;

endpackage

// File: rtl/hpi_access_ctrl_timer.sv
// Phase timer: loadable 4-bit down-counter.
// Zero flag marks the last cycle of a phase.
module hpi_phase_timer (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       load_i,
  input  logic [3:0] val_i,
  output logic       zero_o
);

  logic [3:0] cnt_q;

  // Load on phase entry, otherwise count down to zero and stick.
  always_ff @(posedge clk_i) begin
    if (reset_i)
      cnt_q <= 4'd0;
    else if (load_i)
      cnt_q <= val_i;
    else if (cnt_q != 4'd0)
      cnt_q <= cnt_q - 4'd1;
  end

  assign zero_o = (cnt_q == 4'd0);

endmodule

// File: rtl/hpi_access_ctrl.sv
// Avalon-MM slave to HPI bus access sequencer.
// All HPI outputs are registered from the next state.
module hpi_access_ctrl
  import hpi_ctrl_pkg::*;
#(
  parameter int SETUP_CYC   = 2,
  parameter int STROBE_CYC  = 4,
  parameter int HOLD_CYC    = 2,
  parameter int RECOVER_CYC = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        read,
  input  logic        write,
  input  logic [15:0] writedata,
  output logic [15:0] readdata,
  output logic        waitrequest,
  output logic [1:0]  otg_hpi_address,
  output logic        otg_hpi_cs_n,
  output logic        otg_hpi_r_n,
  output logic        otg_hpi_w_n,
  output logic [15:0] otg_hpi_data_out,
  output logic        otg_hpi_data_oe,
  input  logic [15:0] otg_hpi_data_in,
  output logic        busy
);

  localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC - 1);
  localparam logic [3:0] STROBE_LD = 4'(STROBE_CYC - 1);
  localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYC - 1);
  localparam logic [3:0] RECOV_LD  =
    (RECOVER_CYC == 0) ? 4'd0 : 4'(RECOVER_CYC - 1);

  hpi_state_e  state_q, state_d;
  logic        wr_q, wr_d;
  logic [1:0]  addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rdata_q, rdata_d;
  logic        cs_n_q, cs_n_d;
  logic        r_n_q, r_n_d;
  logic        w_n_q, w_n_d;
  logic        oe_q, oe_d;
  logic        wait_q, wait_d;
  logic        busy_q, busy_d;
  logic        t_load;
  logic [3:0]  t_val;
  logic        t_zero;
  logic        active;
  logic        strobe;

  hpi_phase_timer u_timer (
    .clk_i   (clk),
    .reset_i (reset),
    .load_i  (t_load),
    .val_i   (t_val),
    .zero_o  (t_zero)
  );

  // Next state, phase timer loads and request latching.
  always_comb begin
    state_d = state_q;
    t_load  = 1'b0;
    t_val   = 4'd0;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (chipselect && (read || write)) begin
          state_d = ST_SETUP;
          t_load  = 1'b1;
          t_val   = SETUP_LD;
          wr_d    = write;
          addr_d  = address;
          wdata_d = writedata;
        end
      end
      ST_SETUP: begin
        if (t_zero) begin
          state_d = ST_STROBE;
          t_load  = 1'b1;
          t_val   = STROBE_LD;
        end
      end
      ST_STROBE: begin
        if (t_zero) begin
          state_d = ST_HOLD;
          t_load  = 1'b1;
          t_val   = HOLD_LD;
          if (!wr_q)
            rdata_d = otg_hpi_data_in;
        end
      end
      ST_HOLD: begin
        if (t_zero)
          state_d = ST_DONE;
      end
      ST_DONE: begin
        if (RECOVER_CYC == 0) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RECOVER;
          t_load  = 1'b1;
          t_val   = RECOV_LD;
        end
      end
      ST_RECOVER: begin
        if (t_zero)
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output values for the state being entered.
  always_comb begin
    active = (state_d == ST_SETUP) ||
             (state_d == ST_STROBE) ||
             (state_d == ST_HOLD);
    strobe = (state_d == ST_STROBE);
    cs_n_d = !active;
    r_n_d  = !(strobe && !wr_d);
    w_n_d  = !(strobe && wr_d);
    oe_d   = active && wr_d;
    wait_d = (state_d != ST_DONE);
    busy_d = (state_d != ST_IDLE);
  end

  // State, latched request and registered HPI outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      wr_q    <= 1'b0;
      addr_q  <= 2'd0;
      wdata_q <= 16'd0;
      rdata_q <= 16'd0;
      cs_n_q  <= 1'b1;
      r_n_q   <= 1'b1;
      w_n_q   <= 1'b1;
      oe_q    <= 1'b0;
      wait_q  <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cs_n_q  <= cs_n_d;
      r_n_q   <= r_n_d;
      w_n_q   <= w_n_d;
      oe_q    <= oe_d;
      wait_q  <= wait_d;
      busy_q  <= busy_d;
    end
  end

  assign readdata         = rdata_q;
  assign waitrequest      = wait_q;
  assign otg_hpi_address  = addr_q;
  assign otg_hpi_cs_n     = cs_n_q;
  assign otg_hpi_r_n      = r_n_q;
  assign otg_hpi_w_n      = w_n_q;
  assign otg_hpi_data_out = wdata_q;
  assign otg_hpi_data_oe  = oe_q;
  assign busy             = busy_q;

endmodule

// File: doc/hpi_access_ctrl.md
HPI_ACCESS_CTRL -- requirements
Module: hpi_access_ctrl

Interface
REQ-001 Parameter SETUP_CYC, default 2: cycles address/CS valid before strobe (range 1..15).
REQ-002 Parameter STROBE_CYC, default 4: cycles R_N/W_N held low (range 1..15).
REQ-003 Parameter HOLD_CYC, default 2: cycles address/CS/data held after strobe release (range 1..15).
REQ-004 Parameter RECOVER_CYC, default 3: idle cycles enforced between HPI accesses (range 0..15).
REQ-005 clk  in  1  single clock; all logic rising-edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 address  in  2  Avalon word address; passed directly as HPI register select (0 DATA, 1 MAILBOX, 2 ADDRESS, 3 STATUS).
REQ-008 chipselect  in  1  Avalon slave select.
REQ-009 read  in  1  Avalon read request.
REQ-010 write  in  1  Avalon write request.
REQ-011 writedata  in  16  Avalon write data.
REQ-012 readdata  out  16  data captured from HPI bus.
REQ-013 waitrequest  out  1  Avalon stall; low only in the completion cycle.
REQ-014 otg_hpi_address  out  2  HPI register select.
REQ-015 otg_hpi_cs_n  out  1  HPI chip select, active-low.
REQ-016 otg_hpi_r_n  out  1  HPI read strobe, active-low.
REQ-017 otg_hpi_w_n  out  1  HPI write strobe, active-low.
REQ-018 otg_hpi_data_out  out  16  data driven to HPI pad.
REQ-019 otg_hpi_data_oe  out  1  pad output enable, high drives data_out.
REQ-020 otg_hpi_data_in  in  16  data from HPI pad.
REQ-021 busy  out  1  high whenever state is not IDLE.

Function
REQ-022 FSM states: IDLE, SETUP, STROBE, HOLD, DONE, RECOVER; all HPI outputs registered.
REQ-023 IDLE: on chipselect & (read | write) latch address, writedata, direction; next SETUP.
REQ-024 Simultaneous read & write: write SHALL win.
REQ-025 SETUP lasts SETUP_CYC cycles: cs_n=0, address valid, r_n=w_n=1; data_oe=1 for writes.
REQ-026 STROBE lasts STROBE_CYC cycles: r_n=0 (read) or w_n=0 (write); other signals as in SETUP.
REQ-027 readdata SHALL capture otg_hpi_data_in on the last STROBE cycle and hold until next read capture.
REQ-028 HOLD lasts HOLD_CYC cycles: strobes=1, cs_n=0, address and (write) data_oe/data_out held.
REQ-029 DONE lasts exactly 1 cycle: cs_n=1, data_oe=0, waitrequest=0; next RECOVER, or IDLE if RECOVER_CYC=0.
REQ-030 RECOVER lasts RECOVER_CYC cycles, all HPI strobes/CS inactive; new requests stall (waitrequest=1).
REQ-031 waitrequest = 1 in every state except DONE, including IDLE.
REQ-032 Latency: request seen in IDLE at cycle 0 -> waitrequest low at cycle SETUP_CYC+STROBE_CYC+HOLD_CYC+1.
REQ-033 r_n and w_n SHALL never be low simultaneously; data_oe SHALL never be high during a read access.
REQ-034 Request dropped mid-access (illegal Avalon): access SHALL complete unchanged on HPI.
REQ-035 Phase timing via 4-bit down-counter loaded with (N-1) on state entry; transition when counter is 0.

Reset
REQ-036 reset SHALL force IDLE on next edge, including mid-access.
REQ-037 Reset values: cs_n=1, r_n=1, w_n=1, data_oe=0, data_out=0, otg_hpi_address=0, readdata=0, waitrequest=1, busy=0.

Structure
REQ-038 Package hpi_ctrl_pkg holds state enum and HPI register address constants (DATA, MAILBOX, ADDRESS, STATUS).
REQ-039 One sub-module hpi_phase_timer (loadable 4-bit down-counter with zero flag); FSM and datapath in top.

Verification (defaults 2/4/2/3)
REQ-040 Write addr=2 data=0x1234 -> cs_n low 8 cycles, w_n low cycles 3..6, data_out=0x1234 with oe=1 throughout, waitrequest low cycle 9.
REQ-041 Read addr=0, pad=0xBEEF during strobe -> r_n low 4 cycles, oe=0, readdata=0xBEEF at waitrequest low.
REQ-042 Back-to-back writes held asserted -> second cs_n falling edge no earlier than 4 cycles after first DONE.
REQ-043 read=write=1 addr=1 -> write cycle, w_n toggles, r_n stays 1.
REQ-044 reset asserted during STROBE -> next edge cs_n=w_n=r_n=1, oe=0, busy=0, waitrequest=1.
REQ-045 Assertion over all tests: never (r_n==0 && w_n==0); never (oe && read access).
